// File: rtl/mc_control_fsm_pkg.sv
// ---------------------------------------------------------------------------
// mc_control_fsm_pkg
//   Shared definitions for the multicycle CPU control unit: opcodes, state
//   encodings, ALU operation codes, PC source and destination-register codes.
//   Imported by the control FSM, its decoder, the ALU and the testbench.
// ---------------------------------------------------------------------------
package mc_control_fsm_pkg;

    localparam int OPW    = 6;
    localparam int ALUOPW = 3;

    // Encodings are visible on the debug 'state' port, so they are fixed.
    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_L   = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_t;

    // Opcodes (ins[31:26])
    localparam logic [OPW-1:0] OP_ADD  = 6'b000000;
    localparam logic [OPW-1:0] OP_SUB  = 6'b000001;
    localparam logic [OPW-1:0] OP_ADDI = 6'b000010;
    localparam logic [OPW-1:0] OP_OR   = 6'b010000;
    localparam logic [OPW-1:0] OP_AND  = 6'b010001;
    localparam logic [OPW-1:0] OP_ORI  = 6'b010010;
    localparam logic [OPW-1:0] OP_SLL  = 6'b011000;
    localparam logic [OPW-1:0] OP_SLT  = 6'b100110;
    localparam logic [OPW-1:0] OP_SW   = 6'b110000;
    localparam logic [OPW-1:0] OP_LW   = 6'b110001;
    localparam logic [OPW-1:0] OP_BEQ  = 6'b110100;
    localparam logic [OPW-1:0] OP_BLTZ = 6'b110110;
    localparam logic [OPW-1:0] OP_J    = 6'b111000;
    localparam logic [OPW-1:0] OP_JR   = 6'b111001;
    localparam logic [OPW-1:0] OP_JAL  = 6'b111010;
    localparam logic [OPW-1:0] OP_HALT = 6'b111111;

    // ALU operation select
    localparam logic [ALUOPW-1:0] ALU_ADD = 3'b000;
    localparam logic [ALUOPW-1:0] ALU_SUB = 3'b001;
    localparam logic [ALUOPW-1:0] ALU_SLL = 3'b010;
    localparam logic [ALUOPW-1:0] ALU_OR  = 3'b011;
    localparam logic [ALUOPW-1:0] ALU_AND = 3'b100;
    localparam logic [ALUOPW-1:0] ALU_SLT = 3'b101;

    // Next-PC source
    localparam logic [1:0] PC_NEXT   = 2'b00;  // PC+4
    localparam logic [1:0] PC_BRANCH = 2'b01;  // PC+4+(imm<<2)
    localparam logic [1:0] PC_RS     = 2'b10;  // jr
    localparam logic [1:0] PC_JUMP   = 2'b11;  // j / jal target

    // Register-file write destination
    localparam logic [1:0] WR_RA = 2'b00;  // $31 for jal
    localparam logic [1:0] WR_RT = 2'b01;
    localparam logic [1:0] WR_RD = 2'b10;

endpackage

// File: rtl/mc_control_fsm_decode.sv
// ---------------------------------------------------------------------------
// mc_control_fsm_decode
//   Purely combinational opcode decoder. Classifies the instruction and
//   produces the datapath selects that depend only on the opcode.
// Ports
//   op         in   6   opcode from IR
//   is_alu     out  1   R- or I-type ALU instruction (EXE_AL/WB_AL path)
//   is_imm     out  1   ALU instruction with immediate operand (writes rt)
//   is_br      out  1   beq / bltz
//   is_ls      out  1   lw / sw
//   is_jmp     out  1   j / jr / jal
//   is_halt    out  1   halt
//   alu_op     out  3   ALU operation
//   ext_sel    out  1   1 = sign extend immediate, 0 = zero extend
//   alu_src_a  out  1   1 = shift amount, 0 = rs
//   alu_src_b  out  1   1 = extended immediate, 0 = rt
// ---------------------------------------------------------------------------
module mc_control_fsm_decode
    import mc_control_fsm_pkg::*;
(
    input  logic [OPW-1:0]    op,
    output logic              is_alu,
    output logic              is_imm,
    output logic              is_br,
    output logic              is_ls,
    output logic              is_jmp,
    output logic              is_halt,
    output logic [ALUOPW-1:0] alu_op,
    output logic              ext_sel,
    output logic              alu_src_a,
    output logic              alu_src_b
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        is_alu    = 1'b0;
        is_imm    = 1'b0;
        is_br     = 1'b0;
        is_ls     = 1'b0;
        is_jmp    = 1'b0;
        is_halt   = 1'b0;
        alu_op    = ALU_ADD;
        ext_sel   = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;

        case (op)
            OP_ADD:  is_alu = 1'b1;
            OP_SUB:  begin is_alu = 1'b1; alu_op = ALU_SUB; end
            OP_ADDI: begin is_alu = 1'b1; is_imm = 1'b1; ext_sel = 1'b1; alu_src_b = 1'b1; end
            OP_OR:   begin is_alu = 1'b1; alu_op = ALU_OR; end
            OP_AND:  begin is_alu = 1'b1; alu_op = ALU_AND; end
            OP_ORI:  begin is_alu = 1'b1; is_imm = 1'b1; alu_op = ALU_OR; alu_src_b = 1'b1; end
            // sll shifts rt by the sa field, so A takes sa and B stays rt.
            OP_SLL:  begin is_alu = 1'b1; alu_op = ALU_SLL; alu_src_a = 1'b1; end
            OP_SLT:  begin is_alu = 1'b1; alu_op = ALU_SLT; end
            OP_SW,
            OP_LW:   begin is_ls = 1'b1; ext_sel = 1'b1; alu_src_b = 1'b1; end
            // Branches compare via subtraction: zero for beq, sign for bltz.
            OP_BEQ,
            OP_BLTZ: begin is_br = 1'b1; alu_op = ALU_SUB; ext_sel = 1'b1; end
            OP_J,
            OP_JR,
            OP_JAL:  is_jmp = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: ;  // unknown opcode: no class, behaves as nop
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mc_control_fsm
//   Multicycle CPU control unit. Steps each instruction through
//   IF/ID/EXE/MEM/WB and drives every datapath enable and mux select.
//   All outputs are combinational from (state, op, zero, sign).
// Ports
//   CLK        in   1   clock, all state changes on posedge
//   Reset      in   1   synchronous active-high, returns to sIF, clears halt
//   op         in   6   opcode from IR (valid from sID)
//   zero       in   1   ALU result == 0
//   sign       in   1   ALU result MSB
//   PCWre      out  1   PC write, only in the last state of an instruction
//   IRWre      out  1   IR load (sIF)
//   InsMemRW   out  1   instruction memory read (sIF)
//   RegWre     out  1   register-file write
//   WrRegSel   out  2   write destination ($31 / rt / rd)
//   ALUSrcA    out  1   1 = sa, 0 = rs
//   ALUSrcB    out  1   1 = extended imm, 0 = rt
//   ExtSel     out  1   1 = sign extend
//   ALUOp      out  3   ALU operation
//   mRD        out  1   data memory read (sMEM, lw)
//   mWR        out  1   data memory write (sMEM, sw)
//   DBDataSrc  out  1   1 = memory data to write-back
//   PCSrc      out  2   next-PC source
//   state      out  3   current state (debug)
// ---------------------------------------------------------------------------
module mc_control_fsm
    import mc_control_fsm_pkg::*;
#(
    parameter int OPW    = 6,
    parameter int ALUOPW = 3
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [OPW-1:0]    op,
    input  logic              zero,
    input  logic              sign,
    output logic              PCWre,
    output logic              IRWre,
    output logic              InsMemRW,
    output logic              RegWre,
    output logic [1:0]        WrRegSel,
    output logic              ALUSrcA,
    output logic              ALUSrcB,
    output logic              ExtSel,
    output logic [ALUOPW-1:0] ALUOp,
    output logic              mRD,
    output logic              mWR,
    output logic              DBDataSrc,
    output logic [1:0]        PCSrc,
    output logic [2:0]        state
);

    state_t state_q, state_d;
    logic   halted_q, halted_d;

    logic is_alu, is_imm, is_br, is_ls, is_jmp, is_halt;

    mc_control_fsm_decode u_decode (
        .op        (op),
        .is_alu    (is_alu),
        .is_imm    (is_imm),
        .is_br     (is_br),
        .is_ls     (is_ls),
        .is_jmp    (is_jmp),
        .is_halt   (is_halt),
        .alu_op    (ALUOp),
        .ext_sel   (ExtSel),
        .alu_src_a (ALUSrcA),
        .alu_src_b (ALUSrcB)
    );

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values regardless of statement order.
        if (Reset) begin
            state_q  <= S_IF;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    assign state = state_q;

    // The destination only matters while RegWre is high, so it follows the
    // opcode directly.
    always_comb begin
        if (op == OP_JAL)              WrRegSel = WR_RA;
        else if (is_imm || op == OP_LW) WrRegSel = WR_RT;
        else                           WrRegSel = WR_RD;
    end

    always_comb begin
        state_d   = state_q;
        halted_d  = halted_q;
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        InsMemRW  = 1'b0;
        RegWre    = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        DBDataSrc = 1'b0;
        PCSrc     = PC_NEXT;

        case (state_q)
            S_IF: begin
                IRWre    = 1'b1;
                InsMemRW = 1'b1;
                state_d  = S_ID;
            end
            S_ID: begin
                // Halt parks the FSM in sID with every enable low.
                if (halted_q || is_halt) begin
                    halted_d = 1'b1;
                end else if (is_br) begin
                    state_d = S_EXE_BR;
                end else if (is_ls) begin
                    state_d = S_EXE_LS;
                end else if (is_alu) begin
                    state_d = S_EXE_AL;
                end else begin
                    // Jumps finish here; unknown opcodes fall through as nop.
                    PCWre   = 1'b1;
                    state_d = S_IF;
                    if (op == OP_JR)  PCSrc = PC_RS;
                    else if (is_jmp)  PCSrc = PC_JUMP;
                    if (op == OP_JAL) RegWre = 1'b1;
                end
            end
            S_EXE_AL: state_d = S_WB_AL;
            S_WB_AL: begin
                RegWre  = 1'b1;
                PCWre   = 1'b1;
                state_d = S_IF;
            end
            S_EXE_BR: begin
                PCWre   = 1'b1;
                state_d = S_IF;
                if ((op == OP_BEQ && zero) || (op == OP_BLTZ && sign))
                    PCSrc = PC_BRANCH;
            end
            S_EXE_LS: state_d = S_MEM;
            S_MEM: begin
                if (op == OP_LW) begin
                    mRD     = 1'b1;
                    state_d = S_WB_L;
                end else begin
                    mWR     = 1'b1;
                    PCWre   = 1'b1;
                    state_d = S_IF;
                end
            end
            S_WB_L: begin
                RegWre    = 1'b1;
                DBDataSrc = 1'b1;
                PCWre     = 1'b1;
                state_d   = S_IF;
            end
            default: state_d = S_IF;
        endcase

        // A reset cycle must not commit anything, even mid-instruction.
        if (Reset) begin
            PCWre    = 1'b0;
            IRWre    = 1'b0;
            InsMemRW = 1'b0;
            RegWre   = 1'b0;
            mRD      = 1'b0;
            mWR      = 1'b0;
            PCSrc    = PC_NEXT;
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_control_fsm
//   Self-checking bench for mc_control_fsm. Expected behaviour comes from a
//   per-instruction reference: instruction kind -> latency, state trace and
//   which cycle each enable fires in.
// ---------------------------------------------------------------------------
module tb_mc_control_fsm;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [5:0] op;
    logic       zero, sign;
    logic       PCWre, IRWre, InsMemRW, RegWre, ALUSrcA, ALUSrcB, ExtSel;
    logic       mRD, mWR, DBDataSrc;
    logic [1:0] WrRegSel, PCSrc;
    logic [2:0] ALUOp, state;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    mc_control_fsm dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .op        (op),
        .zero      (zero),
        .sign      (sign),
        .PCWre     (PCWre),
        .IRWre     (IRWre),
        .InsMemRW  (InsMemRW),
        .RegWre    (RegWre),
        .WrRegSel  (WrRegSel),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ExtSel    (ExtSel),
        .ALUOp     (ALUOp),
        .mRD       (mRD),
        .mWR       (mWR),
        .DBDataSrc (DBDataSrc),
        .PCSrc     (PCSrc),
        .state     (state)
    );

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (op=%b t=%0t)", tag, act, exp, op, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {K_RALU, K_IALU, K_BR, K_SW, K_LW, K_JMP, K_NOP} kind_t;

    function automatic kind_t kind_of(input logic [5:0] o);
        case (o)
            6'b000000, 6'b000001, 6'b010000, 6'b010001,
            6'b011000, 6'b100110:              return K_RALU;
            6'b000010, 6'b010010:              return K_IALU;
            6'b110100, 6'b110110:              return K_BR;
            6'b110000:                         return K_SW;
            6'b110001:                         return K_LW;
            6'b111000, 6'b111001, 6'b111010:   return K_JMP;
            default:                           return K_NOP;
        endcase
    endfunction

    function automatic int latency(input kind_t k);
        case (k)
            K_JMP, K_NOP:          return 2;
            K_BR:                  return 3;
            K_RALU, K_IALU, K_SW:  return 4;
            default:               return 5;  // lw
        endcase
    endfunction

    // State visited in cycle c of an instruction of kind k.
    function automatic logic [2:0] exp_state(input kind_t k, input int c);
        case (c)
            0: return 3'b000;
            1: return 3'b001;
            2: return (k == K_BR) ? 3'b101 : (k == K_SW || k == K_LW) ? 3'b010 : 3'b110;
            3: return (k == K_SW || k == K_LW) ? 3'b011 : 3'b111;
            default: return 3'b100;
        endcase
    endfunction

    // {ALUOp, ExtSel, ALUSrcA, ALUSrcB} expected during execute.
    function automatic logic [5:0] exp_alu(input logic [5:0] o);
        case (o)
            6'b000001:            return {3'b001, 3'b000};  // sub
            6'b000010:            return {3'b000, 3'b101};  // addi
            6'b010000:            return {3'b011, 3'b000};  // or
            6'b010001:            return {3'b100, 3'b000};  // and
            6'b010010:            return {3'b011, 3'b001};  // ori
            6'b011000:            return {3'b010, 3'b010};  // sll
            6'b100110:            return {3'b101, 3'b000};  // slt
            6'b110000, 6'b110001: return {3'b000, 3'b101};  // sw/lw
            6'b110100, 6'b110110: return {3'b001, 3'b100};  // beq/bltz
            default:              return {3'b000, 3'b000};  // add
        endcase
    endfunction

    task automatic check_cycle(input logic [5:0] o, input logic z, input logic s, input int c);
        kind_t      k    = kind_of(o);
        int         lat  = latency(k);
        logic       last = (c == lat - 1);
        logic       rw;
        logic [1:0] pcs;
        logic [5:0] a;

        rw = (o == 6'b111010 && c == 1) || ((k == K_RALU || k == K_IALU) && c == 3)
             || (k == K_LW && c == 4);
        pcs = 2'b00;
        if (last) begin
            if (o == 6'b111001)                       pcs = 2'b10;
            else if (k == K_JMP)                      pcs = 2'b11;
            else if (o == 6'b110100 && z)             pcs = 2'b01;
            else if (o == 6'b110110 && s)             pcs = 2'b01;
        end

        check("state",    {5'd0, state},   {5'd0, exp_state(k, c)});
        check("IRWre",    {7'd0, IRWre},   {7'd0, c == 0});
        check("InsMemRW", {7'd0, InsMemRW},{7'd0, c == 0});
        check("PCWre",    {7'd0, PCWre},   {7'd0, last});
        check("mRD",      {7'd0, mRD},     {7'd0, k == K_LW && c == 3});
        check("mWR",      {7'd0, mWR},     {7'd0, k == K_SW && c == 3});
        check("RegWre",   {7'd0, RegWre},  {7'd0, rw});
        check("PCSrc",    {6'd0, PCSrc},   {6'd0, pcs});
        check("mWR&RegWre", {7'd0, mWR & RegWre}, 8'd0);
        check("PCWre&IRWre", {7'd0, PCWre & IRWre}, 8'd0);
        if (rw) begin
            check("WrRegSel", {6'd0, WrRegSel},
                  (o == 6'b111010) ? 8'd0 : (k == K_IALU || k == K_LW) ? 8'd1 : 8'd2);
            check("DBDataSrc", {7'd0, DBDataSrc}, {7'd0, k == K_LW});
        end
        if (c == 2 && k != K_JMP && k != K_NOP) begin
            a = exp_alu(o);
            check("ALUOp",   {5'd0, ALUOp},   {5'd0, a[5:3]});
            check("ALUSrcA", {7'd0, ALUSrcA}, {7'd0, a[1]});
            check("ALUSrcB", {7'd0, ALUSrcB}, {7'd0, a[0]});
            if (k != K_RALU) check("ExtSel", {7'd0, ExtSel}, {7'd0, a[2]});
        end
    endtask

    // Entered #1 after a posedge with the FSM in sIF; leaves the same way.
    task automatic run_instr(input logic [5:0] o, input logic z, input logic s);
        int lat = latency(kind_of(o));
        op   = o;
        zero = z;
        sign = s;
        for (int c = 0; c < lat; c++) begin
            @(negedge CLK);
            check_cycle(o, z, s, c);
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".PCWre"},  {7'd0, PCWre},  8'd0);
        check({tag, ".IRWre"},  {7'd0, IRWre},  8'd0);
        check({tag, ".RegWre"}, {7'd0, RegWre}, 8'd0);
        check({tag, ".mRD"},    {7'd0, mRD},    8'd0);
        check({tag, ".mWR"},    {7'd0, mWR},    8'd0);
        check({tag, ".PCSrc"},  {6'd0, PCSrc},  8'd0);
    endtask

    logic [5:0] op_pool [17] = '{
        6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010,
        6'b011000, 6'b100110, 6'b110000, 6'b110001, 6'b110100, 6'b110110,
        6'b111000, 6'b111001, 6'b111010, 6'b000011, 6'b101010
    };

    initial begin
        Reset = 1'b1;
        op    = 6'b000000;
        zero  = 1'b0;
        sign  = 1'b0;

        // Reset held for two cycles; enables must stay low during reset.
        @(posedge CLK); #1;
        @(negedge CLK);
        check_quiet("reset");
        check("reset.state", {5'd0, state}, 8'd0);
        @(posedge CLK); #1;
        Reset = 1'b0;

        // Directed: add, lw, beq taken / not taken, bltz, jal, jr, illegal
        run_instr(6'b000000, 1'b0, 1'b0);
        run_instr(6'b110001, 1'b0, 1'b0);
        run_instr(6'b110100, 1'b1, 1'b0);
        run_instr(6'b110100, 1'b0, 1'b0);
        run_instr(6'b110110, 1'b0, 1'b1);
        run_instr(6'b111010, 1'b0, 1'b0);
        run_instr(6'b111001, 1'b0, 1'b0);
        run_instr(6'b101010, 1'b1, 1'b1);

        // Randomized instruction stream
        for (int i = 0; i < 80; i++)
            run_instr(op_pool[$urandom_range(0, 16)], 1'($urandom), 1'($urandom));

        // Reset during sMEM of sw: no write, no PC update, back to sIF.
        op = 6'b110000;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            check_cycle(6'b110000, 1'b0, 1'b0, c);
            @(posedge CLK); #1;
        end
        Reset = 1'b1;
        @(negedge CLK);
        check("rst_mem.state", {5'd0, state}, 8'd3);
        check_quiet("rst_mem");
        @(posedge CLK); #1;
        Reset = 1'b0;
        run_instr(6'b000000, 1'b0, 1'b0);

        // halt: parked in sID with nothing enabled, whatever op shows next.
        op = 6'b111111;
        @(negedge CLK);
        check("halt.fetch", {7'd0, IRWre}, 8'd1);
        @(posedge CLK); #1;
        for (int i = 0; i < 21; i++) begin
            @(negedge CLK);
            check("halt.state", {5'd0, state}, 8'd1);
            check_quiet("halt");
            @(posedge CLK); #1;
            op   = op_pool[$urandom_range(0, 16)];
            zero = 1'($urandom);
            sign = 1'($urandom);
        end
        Reset = 1'b1;
        @(negedge CLK);
        check_quiet("halt_rst");
        @(posedge CLK); #1;
        Reset = 1'b0;
        run_instr(6'b000000, 1'b0, 1'b0);
        run_instr(6'b110000, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
